// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU execute-stage definitions.
// Holds the CODE_ALU_EX_* control codes produced by alu_control, the
// execute-unit state encoding and code-classification helpers. The hazard
// unit imports is_shift_code() from here to spot multi-cycle operations.
package alu_exec_unit_pkg;

  localparam int unsigned CODE_ALU_EX_W = 4;

  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_NOP  = 4'h0;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_ADD  = 4'h1;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_ADDU = 4'h2;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_SUB  = 4'h3;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_SUBU = 4'h4;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_AND  = 4'h5;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_OR   = 4'h6;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_XOR  = 4'h7;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_NOR  = 4'h8;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_SLT  = 4'h9;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_SLL  = 4'hA;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_SRL  = 4'hB;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_SRA  = 4'hC;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_SLLV = 4'hD;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_SRLV = 4'hE;
  localparam logic [CODE_ALU_EX_W-1:0] CODE_ALU_EX_SRAV = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_exec_state_e;

  // True for every code that goes through the iterative shifter.
  function automatic logic is_shift_code(input logic [CODE_ALU_EX_W-1:0] code);
    return code inside {CODE_ALU_EX_SLL, CODE_ALU_EX_SRL, CODE_ALU_EX_SRA,
                        CODE_ALU_EX_SLLV, CODE_ALU_EX_SRLV, CODE_ALU_EX_SRAV};
  endfunction

  // Variable shifts take their amount from operand A instead of shamt.
  function automatic logic is_var_shift_code(input logic [CODE_ALU_EX_W-1:0] code);
    return code inside {CODE_ALU_EX_SLLV, CODE_ALU_EX_SRLV, CODE_ALU_EX_SRAV};
  endfunction

  function automatic logic is_left_shift_code(input logic [CODE_ALU_EX_W-1:0] code);
    return code inside {CODE_ALU_EX_SLL, CODE_ALU_EX_SLLV};
  endfunction

  function automatic logic is_arith_shift_code(input logic [CODE_ALU_EX_W-1:0] code);
    return code inside {CODE_ALU_EX_SRA, CODE_ALU_EX_SRAV};
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter.
// Ports:
//   i_clk, i_reset   clock, synchronous active-low reset
//   i_load           capture i_data/i_amount/direction/arith
//   i_enable         perform one shift step while the counter is non-zero
//   i_dir_left       1 = shift left (zero fill at LSB), 0 = shift right
//   i_arith          right shifts replicate the loaded MSB instead of 0
//   i_data           value to be shifted
//   i_amount         number of steps
//   o_data           working register
//   o_data_next      working register after one more step
//   o_done           the step about to be taken is the last one
module alu_shift_iter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_enable,
  input  logic               i_dir_left,
  input  logic               i_arith,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_amount,
  output logic [DATA_W-1:0]  o_data,
  output logic [DATA_W-1:0]  o_data_next,
  output logic               o_done
);

  logic [DATA_W-1:0]  work_q,  work_d;
  logic [SHAMT_W-1:0] cnt_q,   cnt_d;
  logic               left_q,  left_d;
  logic               fill_q,  fill_d;

  always_comb begin
    if (left_q) o_data_next = {work_q[DATA_W-2:0], 1'b0};
    else        o_data_next = {fill_q, work_q[DATA_W-1:1]};
  end

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    left_d = left_q;
    fill_d = fill_q;
    if (i_load) begin
      work_d = i_data;
      cnt_d  = i_amount;
      left_d = i_dir_left;
      // The fill bit is frozen at load time so SRA replicates the original MSB.
      fill_d = i_arith & ~i_dir_left & i_data[DATA_W-1];
    end else if (i_enable && (cnt_q != '0)) begin
      work_d = o_data_next;
      cnt_d  = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      work_q <= '0;
      cnt_q  <= '0;
      left_q <= 1'b0;
      fill_q <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      left_q <= left_d;
      fill_q <= fill_d;
    end
  end

  assign o_data = work_q;
  assign o_done = (cnt_q == SHAMT_W'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops produce a result one cycle after accept; shifts run
// through alu_shift_iter at one bit per cycle and stall the request side.
// Ports:
//   i_clk, i_reset        clock, synchronous active-low reset
//   i_valid / o_ready     request handshake (accepted only in IDLE)
//   i_alu_ctr             CODE_ALU_EX_* operation code
//   i_data_a, i_data_b    operands; B is the value shifted
//   i_shamt               shift amount for SLL/SRL/SRA
//   o_valid / i_ready     result handshake
//   o_result              registered result
//   o_zero                o_result == 0
//   o_overflow            signed overflow for ADD/SUB
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH    = 32,
  parameter int unsigned ALU_CTR_BUS_WIDTH = 4,
  parameter int unsigned SHAMT_BUS_WIDTH   = 5
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [ALU_CTR_BUS_WIDTH-1:0] i_alu_ctr,
  input  logic [DATA_BUS_WIDTH-1:0]    i_data_a,
  input  logic [DATA_BUS_WIDTH-1:0]    i_data_b,
  input  logic [SHAMT_BUS_WIDTH-1:0]   i_shamt,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [DATA_BUS_WIDTH-1:0]    o_result,
  output logic                         o_zero,
  output logic                         o_overflow
);

  localparam int unsigned MSB = DATA_BUS_WIDTH - 1;

  alu_exec_state_e             state_q, state_d;
  logic [DATA_BUS_WIDTH-1:0]   result_q, result_d;
  logic                        ovf_q, ovf_d;

  logic                        accept;
  logic                        shift_op;
  logic [SHAMT_BUS_WIDTH-1:0]  shift_amt;
  logic                        sh_load, sh_enable, sh_done;
  logic [DATA_BUS_WIDTH-1:0]   sh_data, sh_data_next;

  logic [DATA_BUS_WIDTH-1:0]   sum, diff;
  logic [DATA_BUS_WIDTH-1:0]   alu_res;
  logic                        alu_ovf;

  assign accept    = i_valid && (state_q == ST_IDLE);
  assign shift_op  = is_shift_code(i_alu_ctr);
  assign shift_amt = is_var_shift_code(i_alu_ctr) ? i_data_a[SHAMT_BUS_WIDTH-1:0]
                                                  : i_shamt;

  assign sum  = i_data_a + i_data_b;
  assign diff = i_data_a - i_data_b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (i_alu_ctr)
      CODE_ALU_EX_ADD: begin
        alu_res = sum;
        alu_ovf = (i_data_a[MSB] == i_data_b[MSB]) && (sum[MSB] != i_data_a[MSB]);
      end
      CODE_ALU_EX_ADDU: alu_res = sum;
      CODE_ALU_EX_SUB: begin
        alu_res = diff;
        alu_ovf = (i_data_a[MSB] != i_data_b[MSB]) && (diff[MSB] != i_data_a[MSB]);
      end
      CODE_ALU_EX_SUBU: alu_res = diff;
      CODE_ALU_EX_AND:  alu_res = i_data_a & i_data_b;
      CODE_ALU_EX_OR:   alu_res = i_data_a | i_data_b;
      CODE_ALU_EX_XOR:  alu_res = i_data_a ^ i_data_b;
      CODE_ALU_EX_NOR:  alu_res = ~(i_data_a | i_data_b);
      CODE_ALU_EX_SLT:  alu_res = {{(DATA_BUS_WIDTH-1){1'b0}},
                                   ($signed(i_data_a) < $signed(i_data_b))};
      default:          alu_res = '0;
    endcase
  end

  alu_shift_iter #(
    .DATA_W  (DATA_BUS_WIDTH),
    .SHAMT_W (SHAMT_BUS_WIDTH)
  ) u_shift (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (sh_load),
    .i_enable    (sh_enable),
    .i_dir_left  (is_left_shift_code(i_alu_ctr)),
    .i_arith     (is_arith_shift_code(i_alu_ctr)),
    .i_data      (i_data_b),
    .i_amount    (shift_amt),
    .o_data      (sh_data),
    .o_data_next (sh_data_next),
    .o_done      (sh_done)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    sh_load   = 1'b0;
    sh_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ovf_d = alu_ovf;
          if (shift_op && (shift_amt != '0)) begin
            sh_load = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            result_d = shift_op ? i_data_b : alu_res;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        sh_enable = 1'b1;
        // Capture the post-step value so the result is registered on entry to DONE.
        if (sh_done) begin
          result_d = sh_data_next;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_ready    = (state_q == ST_IDLE);
  assign o_valid    = (state_q == ST_DONE);
  assign o_result   = result_q;
  assign o_zero     = (result_q == '0);
  assign o_overflow = ovf_q;

  logic unused_sh_data;
  assign unused_sh_data = ^sh_data;

endmodule
